// File: rtl/router_pkg.sv
// Shared types and constants for the router synchronizer: port count,
// timeout length and the destination address encoding.
package router_pkg;

  localparam int NUM_PORTS = 3;
  localparam int TIMEOUT   = 30;
  localparam int ADDR_W    = 2;
  localparam int CNT_W     = 5;

  typedef logic [ADDR_W-1:0] port_addr_t;

  // Address 3 selects no FIFO; it is also the reset value of the latch.
  localparam port_addr_t ADDR_INVALID = 2'b11;

endpackage

// File: rtl/router_timeout_cnt.sv
// Per-port unread-data watchdog: counts consecutive valid-but-unread cycles
// and emits a one-cycle soft_reset pulse on the TIMEOUT-th one.
module router_timeout_cnt #(
  parameter int TIMEOUT = 30,
  parameter int CNT_W   = 5
) (
  input  logic clk,
  input  logic resetn,
  input  logic valid,
  input  logic read,
  output logic soft_reset
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             soft_reset_q, soft_reset_d;

  // Any read or an empty FIFO restarts the count; wrap to zero on expiry.
  always_comb begin
    cnt_d        = '0;
    soft_reset_d = 1'b0;
    if (valid && !read) begin
      if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
        soft_reset_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q        <= '0;
      soft_reset_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      soft_reset_q <= soft_reset_d;
    end
  end

  assign soft_reset = soft_reset_q;

endmodule

// File: rtl/router_sync_ctrl.sv
// Router synchronizer: latches the header destination, steers FSM writes to
// one FIFO, returns its full flag, and drives per-port valid and soft reset.
module router_sync_ctrl #(
  parameter int NUM_PORTS = router_pkg::NUM_PORTS,
  parameter int TIMEOUT   = router_pkg::TIMEOUT,
  parameter int CNT_W     = router_pkg::CNT_W
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 detect_add,
  input  logic [1:0]           data_in,
  input  logic                 write_enb_reg,
  input  logic [NUM_PORTS-1:0] read_enb,
  input  logic [NUM_PORTS-1:0] empty,
  input  logic [NUM_PORTS-1:0] full,
  output logic [NUM_PORTS-1:0] write_enb,
  output logic                 fifo_full,
  output logic [NUM_PORTS-1:0] valid_out,
  output logic [NUM_PORTS-1:0] soft_reset
);

  import router_pkg::*;

  port_addr_t addr_q, addr_d;

  always_comb begin
    addr_d = addr_q;
    if (detect_add) begin
      addr_d = data_in;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_q <= ADDR_INVALID;
    end else begin
      addr_q <= addr_d;
    end
  end

  // Decode from the latched address only, so a header arriving this cycle
  // cannot redirect a write already in flight. Address 3 matches no port.
  always_comb begin
    write_enb = '0;
    fifo_full = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (addr_q == port_addr_t'(i)) begin
        write_enb[i] = write_enb_reg;
        fifo_full    = full[i];
      end
    end
  end

  assign valid_out = ~empty;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    router_timeout_cnt #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
    ) u_timeout (
      .clk        (clk),
      .resetn     (resetn),
      .valid      (valid_out[g]),
      .read       (read_enb[g]),
      .soft_reset (soft_reset[g])
    );
  end

endmodule
